// File: rtl/ddr4_cmd_scheduler_pkg.sv
// Shared definitions for the DDR4 command scheduler: timing defaults,
// command/request encodings, address field slicing and counter helpers.
package mc_defs;

    // Default DDR4 timing values in clk cycles.
    localparam int T_RP_DEF    = 24;
    localparam int T_RCD_DEF   = 24;
    localparam int T_RAS_DEF   = 52;
    localparam int T_RTP_DEF   = 12;
    localparam int T_WR_DEF    = 20;
    localparam int T_CWD_DEF   = 20;
    localparam int T_BURST_DEF = 4;
    localparam int T_RRD_L_DEF = 6;
    localparam int T_RRD_S_DEF = 4;
    localparam int T_CCD_L_DEF = 8;
    localparam int T_CCD_S_DEF = 4;
    localparam int T_WTR_L_DEF = 12;
    localparam int T_WTR_S_DEF = 4;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [32:0]      addr_t;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_PRE = 3'd1,
        CMD_ACT = 3'd2,
        CMD_RD  = 3'd3,
        CMD_WR  = 3'd4
    } cmd_type_e;

    typedef enum logic [1:0] {
        OP_READ   = 2'd0,
        OP_WRITE  = 2'd1,
        OP_IFETCH = 2'd2
    } req_op_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CHECK    = 3'd1,
        S_PRE      = 3'd2,
        S_ACT      = 3'd3,
        S_COL      = 3'd4,
        S_AUTO_PRE = 3'd5
    } sched_state_e;

    function automatic logic [14:0] addr_row(addr_t a);
        return a[32:18];
    endfunction

    function automatic logic [10:0] addr_col(addr_t a);
        return {a[17:10], a[5:3]};
    endfunction

    function automatic logic [1:0] addr_bank(addr_t a);
        return a[9:8];
    endfunction

    function automatic logic [1:0] addr_bg(addr_t a);
        return a[7:6];
    endfunction

    // A counter holds "cycles until permitted minus one" once registered, so
    // a constraint of N loaded at issue cycle t reaches zero at exactly t+N.
    function automatic cnt_t cnt_load(int n);
        return (n > 0) ? cnt_t'(n - 1) : '0;
    endfunction

    function automatic cnt_t cnt_dec(cnt_t c);
        return (c != '0) ? c - cnt_t'(1) : '0;
    endfunction

    function automatic cnt_t cnt_max(cnt_t a, cnt_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr4_cmd_scheduler_bank_timer.sv
// Per-bank state: open flag, open row and the ACT/column/PRE spacing counters.
module ddr4_bank_timer
    import mc_defs::*;
#(
    parameter int T_RP     = T_RP_DEF,
    parameter int T_RCD    = T_RCD_DEF,
    parameter int T_RAS    = T_RAS_DEF,
    parameter int T_RTP    = T_RTP_DEF,
    parameter int T_WR_PRE = T_CWD_DEF + T_BURST_DEF + T_WR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        do_pre,
    input  logic        do_act,
    input  logic        do_rd,
    input  logic        do_wr,
    input  logic [14:0] act_row,
    output logic        is_open,
    output logic [14:0] open_row,
    output logic        can_act,
    output logic        can_col,
    output logic        can_pre
);

    localparam cnt_t RP_LD     = cnt_load(T_RP);
    localparam cnt_t RCD_LD    = cnt_load(T_RCD);
    localparam cnt_t RAS_LD    = cnt_load(T_RAS);
    localparam cnt_t RTP_LD    = cnt_load(T_RTP);
    localparam cnt_t WR_PRE_LD = cnt_load(T_WR_PRE);

    logic        open_q, open_d;
    logic [14:0] row_q, row_d;
    cnt_t        act_cnt_q, act_cnt_d;
    cnt_t        col_cnt_q, col_cnt_d;
    cnt_t        pre_cnt_q, pre_cnt_d;

    // Count down every cycle; reload on the command that creates a constraint.
    always_comb begin
        open_d    = open_q;
        row_d     = row_q;
        act_cnt_d = cnt_dec(act_cnt_q);
        col_cnt_d = cnt_dec(col_cnt_q);
        pre_cnt_d = cnt_dec(pre_cnt_q);
        if (do_pre) begin
            open_d    = 1'b0;
            act_cnt_d = RP_LD;
        end
        if (do_act) begin
            open_d    = 1'b1;
            row_d     = act_row;
            col_cnt_d = RCD_LD;
            pre_cnt_d = RAS_LD;
        end
        if (do_rd) begin
            pre_cnt_d = cnt_max(cnt_dec(pre_cnt_q), RTP_LD);
        end
        if (do_wr) begin
            pre_cnt_d = cnt_max(cnt_dec(pre_cnt_q), WR_PRE_LD);
        end
    end

    // Bank state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open_q    <= 1'b0;
            row_q     <= '0;
            act_cnt_q <= '0;
            col_cnt_q <= '0;
            pre_cnt_q <= '0;
        end else begin
            open_q    <= open_d;
            row_q     <= row_d;
            act_cnt_q <= act_cnt_d;
            col_cnt_q <= col_cnt_d;
            pre_cnt_q <= pre_cnt_d;
        end
    end

    assign is_open  = open_q;
    assign open_row = row_q;
    assign can_act  = (act_cnt_q == '0);
    assign can_col  = (col_cnt_q == '0);
    assign can_pre  = (pre_cnt_q == '0);

endmodule

// File: rtl/ddr4_cmd_scheduler.sv
// Single-request DDR4 command sequencer (open-page by default).
// Define MC_CLOSED_PAGE_EN to auto-precharge the bank after every RD/WR.
// Handshake: a request transfers in a cycle where req_valid && req_ready;
// req_ready is high only in IDLE and the request fields are latched then.
module ddr4_cmd_scheduler
    import mc_defs::*;
#(
    parameter int T_RP    = T_RP_DEF,
    parameter int T_RCD   = T_RCD_DEF,
    parameter int T_RAS   = T_RAS_DEF,
    parameter int T_RTP   = T_RTP_DEF,
    parameter int T_WR    = T_WR_DEF,
    parameter int T_CWD   = T_CWD_DEF,
    parameter int T_BURST = T_BURST_DEF,
    parameter int T_RRD_L = T_RRD_L_DEF,
    parameter int T_RRD_S = T_RRD_S_DEF,
    parameter int T_CCD_L = T_CCD_L_DEF,
    parameter int T_CCD_S = T_CCD_S_DEF,
    parameter int T_WTR_L = T_WTR_L_DEF,
    parameter int T_WTR_S = T_WTR_S_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [32:0] req_addr,
    output logic        cmd_valid,
    output logic [2:0]  cmd_type,
    output logic [1:0]  cmd_bg,
    output logic [1:0]  cmd_bank,
    output logic [14:0] cmd_row,
    output logic [10:0] cmd_col,
    output logic        page_hit,
    output logic        busy
);

    localparam int WR_PRE  = T_CWD + T_BURST + T_WR;
    localparam int WTR_L_G = T_CWD + T_BURST + T_WTR_L;
    localparam int WTR_S_G = T_CWD + T_BURST + T_WTR_S;

    if (T_RP > CNT_MAX || T_RCD > CNT_MAX || T_RAS > CNT_MAX || T_RTP > CNT_MAX ||
        WR_PRE > CNT_MAX || WTR_L_G > CNT_MAX || WTR_S_G > CNT_MAX ||
        T_RRD_L > CNT_MAX || T_RRD_S > CNT_MAX || T_CCD_L > CNT_MAX ||
        T_CCD_S > CNT_MAX) begin : g_timing_range_check
        $error("ddr4_cmd_scheduler: timing value exceeds the 8-bit counter range");
    end

    localparam cnt_t RRD_L_LD = cnt_load(T_RRD_L);
    localparam cnt_t RRD_S_LD = cnt_load(T_RRD_S);
    localparam cnt_t CCD_L_LD = cnt_load(T_CCD_L);
    localparam cnt_t CCD_S_LD = cnt_load(T_CCD_S);
    localparam cnt_t WTR_L_LD = cnt_load(WTR_L_G);
    localparam cnt_t WTR_S_LD = cnt_load(WTR_S_G);

    sched_state_e state_q, state_d;
    logic         is_wr_q, is_wr_d;
    logic         hit_q, hit_d;
    logic [14:0]  row_q, row_d;
    logic [10:0]  col_q, col_d;
    logic [1:0]   bg_q, bg_d;
    logic [1:0]   bank_q, bank_d;
    logic [3:0]   idx;

    // Global spacing counters; the _l/_s pairs cover same/different bank group.
    cnt_t         rrd_l_q, rrd_l_d, rrd_s_q, rrd_s_d;
    cnt_t         ccd_l_q, ccd_l_d, ccd_s_q, ccd_s_d;
    cnt_t         wtr_l_q, wtr_l_d, wtr_s_q, wtr_s_d;
    logic [1:0]   last_act_bg_q, last_act_bg_d;
    logic [1:0]   last_col_bg_q, last_col_bg_d;
    logic [1:0]   last_wr_bg_q, last_wr_bg_d;

    logic [1:0]   cmd_bg_q, cmd_bg_d, cmd_bank_q, cmd_bank_d;
    logic [14:0]  cmd_row_q, cmd_row_d;
    logic [10:0]  cmd_col_q, cmd_col_d;

    logic         issue;
    cmd_type_e    issue_type;
    logic         is_col_cmd;
    logic         rrd_ok, ccd_ok, wtr_ok;

    logic [15:0]  bank_open, can_act_v, can_col_v, can_pre_v;
    logic [14:0]  bank_row [16];
    logic [15:0]  do_pre_v, do_act_v, do_rd_v, do_wr_v;
    logic [15:0]  idx_onehot;

    assign idx        = {bg_q, bank_q};
    assign idx_onehot = 16'd1 << idx;
    assign is_col_cmd = issue && (issue_type == CMD_RD || issue_type == CMD_WR);

    assign do_pre_v = (issue && issue_type == CMD_PRE) ? idx_onehot : '0;
    assign do_act_v = (issue && issue_type == CMD_ACT) ? idx_onehot : '0;
    assign do_rd_v  = (issue && issue_type == CMD_RD)  ? idx_onehot : '0;
    assign do_wr_v  = (issue && issue_type == CMD_WR)  ? idx_onehot : '0;

    for (genvar i = 0; i < 16; i++) begin : g_bank
        ddr4_bank_timer #(
            .T_RP     (T_RP),
            .T_RCD    (T_RCD),
            .T_RAS    (T_RAS),
            .T_RTP    (T_RTP),
            .T_WR_PRE (WR_PRE)
        ) u_timer (
            .clk      (clk),
            .rst      (rst),
            .do_pre   (do_pre_v[i]),
            .do_act   (do_act_v[i]),
            .do_rd    (do_rd_v[i]),
            .do_wr    (do_wr_v[i]),
            .act_row  (row_q),
            .is_open  (bank_open[i]),
            .open_row (bank_row[i]),
            .can_act  (can_act_v[i]),
            .can_col  (can_col_v[i]),
            .can_pre  (can_pre_v[i])
        );
    end

    assign rrd_ok = (rrd_s_q == '0) && ((bg_q != last_act_bg_q) || (rrd_l_q == '0));
    assign ccd_ok = (ccd_s_q == '0) && ((bg_q != last_col_bg_q) || (ccd_l_q == '0));
    assign wtr_ok = (wtr_s_q == '0) && ((bg_q != last_wr_bg_q) || (wtr_l_q == '0));

    // Next-state and command issue: at most one command per cycle.
    always_comb begin
        state_d    = state_q;
        is_wr_d    = is_wr_q;
        hit_d      = hit_q;
        row_d      = row_q;
        col_d      = col_q;
        bg_d       = bg_q;
        bank_d     = bank_q;
        issue      = 1'b0;
        issue_type = CMD_NOP;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    is_wr_d = (req_op == OP_WRITE);
                    row_d   = addr_row(req_addr);
                    col_d   = addr_col(req_addr);
                    bg_d    = addr_bg(req_addr);
                    bank_d  = addr_bank(req_addr);
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                hit_d = 1'b0;
                if (bank_open[idx] && bank_row[idx] == row_q) begin
                    hit_d   = 1'b1;
                    state_d = S_COL;
                end else if (!bank_open[idx]) begin
                    state_d = S_ACT;
                end else begin
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                if (can_pre_v[idx]) begin
                    issue      = 1'b1;
                    issue_type = CMD_PRE;
                    state_d    = S_ACT;
                end
            end
            S_ACT: begin
                if (can_act_v[idx] && rrd_ok) begin
                    issue      = 1'b1;
                    issue_type = CMD_ACT;
                    state_d    = S_COL;
                end
            end
            S_COL: begin
                if (can_col_v[idx] && ccd_ok && (is_wr_q || wtr_ok)) begin
                    issue      = 1'b1;
                    issue_type = is_wr_q ? CMD_WR : CMD_RD;
`ifdef MC_CLOSED_PAGE_EN
                    state_d    = S_AUTO_PRE;
`else
                    state_d    = S_IDLE;
`endif
                end
            end
            S_AUTO_PRE: begin
                if (can_pre_v[idx]) begin
                    issue      = 1'b1;
                    issue_type = CMD_PRE;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Global ACT/column/write-to-read spacing and the held command fields.
    always_comb begin
        rrd_l_d       = cnt_dec(rrd_l_q);
        rrd_s_d       = cnt_dec(rrd_s_q);
        ccd_l_d       = cnt_dec(ccd_l_q);
        ccd_s_d       = cnt_dec(ccd_s_q);
        wtr_l_d       = cnt_dec(wtr_l_q);
        wtr_s_d       = cnt_dec(wtr_s_q);
        last_act_bg_d = last_act_bg_q;
        last_col_bg_d = last_col_bg_q;
        last_wr_bg_d  = last_wr_bg_q;
        cmd_bg_d      = cmd_bg_q;
        cmd_bank_d    = cmd_bank_q;
        cmd_row_d     = cmd_row_q;
        cmd_col_d     = cmd_col_q;
        if (issue) begin
            cmd_bg_d   = bg_q;
            cmd_bank_d = bank_q;
            cmd_row_d  = row_q;
            cmd_col_d  = col_q;
        end
        if (issue && issue_type == CMD_ACT) begin
            rrd_l_d       = RRD_L_LD;
            rrd_s_d       = RRD_S_LD;
            last_act_bg_d = bg_q;
        end
        if (is_col_cmd) begin
            ccd_l_d       = CCD_L_LD;
            ccd_s_d       = CCD_S_LD;
            last_col_bg_d = bg_q;
        end
        if (issue && issue_type == CMD_WR) begin
            wtr_l_d      = WTR_L_LD;
            wtr_s_d      = WTR_S_LD;
            last_wr_bg_d = bg_q;
        end
    end

    // State, request and counter registers; reset drops any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            is_wr_q       <= 1'b0;
            hit_q         <= 1'b0;
            row_q         <= '0;
            col_q         <= '0;
            bg_q          <= '0;
            bank_q        <= '0;
            rrd_l_q       <= '0;
            rrd_s_q       <= '0;
            ccd_l_q       <= '0;
            ccd_s_q       <= '0;
            wtr_l_q       <= '0;
            wtr_s_q       <= '0;
            last_act_bg_q <= '0;
            last_col_bg_q <= '0;
            last_wr_bg_q  <= '0;
            cmd_bg_q      <= '0;
            cmd_bank_q    <= '0;
            cmd_row_q     <= '0;
            cmd_col_q     <= '0;
        end else begin
            state_q       <= state_d;
            is_wr_q       <= is_wr_d;
            hit_q         <= hit_d;
            row_q         <= row_d;
            col_q         <= col_d;
            bg_q          <= bg_d;
            bank_q        <= bank_d;
            rrd_l_q       <= rrd_l_d;
            rrd_s_q       <= rrd_s_d;
            ccd_l_q       <= ccd_l_d;
            ccd_s_q       <= ccd_s_d;
            wtr_l_q       <= wtr_l_d;
            wtr_s_q       <= wtr_s_d;
            last_act_bg_q <= last_act_bg_d;
            last_col_bg_q <= last_col_bg_d;
            last_wr_bg_q  <= last_wr_bg_d;
            cmd_bg_q      <= cmd_bg_d;
            cmd_bank_q    <= cmd_bank_d;
            cmd_row_q     <= cmd_row_d;
            cmd_col_q     <= cmd_col_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign cmd_valid = issue;
    assign cmd_type  = issue_type;
    assign cmd_bg    = cmd_bg_d;
    assign cmd_bank  = cmd_bank_d;
    assign cmd_row   = cmd_row_d;
    assign cmd_col   = cmd_col_d;

`ifdef MC_CLOSED_PAGE_EN
    assign page_hit = 1'b0;
`else
    assign page_hit = is_col_cmd && hit_q;
`endif

endmodule

// File: tb/tb_ddr4_cmd_scheduler.sv
// Self-checking bench for ddr4_cmd_scheduler (default open-page build).
module tb_ddr4_cmd_scheduler;
    import mc_defs::*;

    localparam int W = 66;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [32:0] req_addr;
    logic        cmd_valid;
    logic [2:0]  cmd_type;
    logic [1:0]  cmd_bg;
    logic [1:0]  cmd_bank;
    logic [14:0] cmd_row;
    logic [10:0] cmd_col;
    logic        page_hit;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int proto_err = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] act_q[$];

    ddr4_cmd_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .cmd_valid (cmd_valid),
        .cmd_type  (cmd_type),
        .cmd_bg    (cmd_bg),
        .cmd_bank  (cmd_bank),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .page_hit  (page_hit),
        .busy      (busy)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Command record {cycle, type, bg, bank, row (ACT only), col (RD/WR only), hit}.
    function automatic logic [W-1:0] pack_cmd(int c, int t, int g, int b, int r, int cl, int h);
        logic [31:0] cc;
        logic [2:0]  tt;
        logic [1:0]  gg, bb;
        logic [14:0] rr;
        logic [10:0] ll;
        logic        hh;
        cc = c;
        tt = 3'(t);
        gg = 2'(g);
        bb = 2'(b);
        rr = (t == 2) ? 15'(r) : 15'd0;
        ll = (t == 3 || t == 4) ? 11'(cl) : 11'd0;
        hh = 1'(h);
        return {cc, tt, gg, bb, rr, ll, hh};
    endfunction

    // Monitor: log every issued command; outside commands type must be NOP and no hit.
    always @(negedge clk) begin
        if (cmd_valid)
            act_q.push_back(pack_cmd(cyc, cmd_type, cmd_bg, cmd_bank, cmd_row, cmd_col, page_hit));
        else if (cmd_type != 3'd0 || page_hit)
            proto_err++;
    end

    function automatic logic [32:0] mk_addr(int bg, int bk, int row, int col);
        logic [32:0] a;
        logic [10:0] c;
        c = 11'(col);
        a = '0;
        a[32:18] = 15'(row);
        a[17:10] = c[10:3];
        a[9:8]   = 2'(bk);
        a[7:6]   = 2'(bg);
        a[5:3]   = c[2:0];
        a[2:0]   = 3'($urandom_range(0, 7));
        return a;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Scoreboard: compare logged commands against expectations, then clear both.
    task automatic check_cmds(input string name);
        logic [W-1:0] a, e;
        total++;
        if (act_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s cmd_count got=%0d exp=%0d", name, act_q.size(), exp_q.size());
        end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s got cyc=%0d type=%0d bg=%0d bank=%0d row=%0h col=%0h hit=%0d exp cyc=%0d type=%0d bg=%0d bank=%0d row=%0h col=%0h hit=%0d",
                         name, a[65:34], a[33:31], a[30:29], a[28:27], a[26:12], a[11:1], a[0],
                         e[65:34], e[33:31], e[30:29], e[28:27], e[26:12], e[11:1], e[0]);
            end
        end
        act_q.delete();
        exp_q.delete();
    endtask

    // Driver: present a request as soon as the scheduler is ready; acc = accept cycle.
    task automatic send_req(input int op, input logic [32:0] addr, output int acc);
        int n;
        n = 0;
        acc = -1;
        while (!req_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout got=0 exp=1");
            return;
        end
        req_valid = 1'b1;
        req_op    = 2'(op);
        req_addr  = addr;
        acc       = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!req_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL idle_timeout got=busy exp=idle");
        end
    endtask

    // Reference model: absolute issue times from the last-command timestamps.
    bit m_open[16];
    int m_row[16];
    int m_act[16], m_pre[16], m_rd[16], m_wr[16];
    int g_act_t, g_act_bg, g_col_t, g_col_bg, g_wr_t, g_wr_bg;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_open[i] = 1'b0;
            m_row[i]  = 0;
            m_act[i]  = -1000;
            m_pre[i]  = -1000;
            m_rd[i]   = -1000;
            m_wr[i]   = -1000;
        end
        g_act_t = -1000; g_act_bg = 0;
        g_col_t = -1000; g_col_bg = 0;
        g_wr_t  = -1000; g_wr_bg  = 0;
    endtask

    task automatic model_req(input int acc, input int op, input int bg, input int bk,
                             input int row, input int col);
        int b, t, tp, ta, tc;
        bit wr, hit;
        b   = bg * 4 + bk;
        t   = acc + 2;
        wr  = (op == 1);
        hit = m_open[b] && (m_row[b] == row);
        if (!hit) begin
            if (m_open[b]) begin
                tp = imax(t, m_act[b] + T_RAS_DEF);
                tp = imax(tp, m_rd[b] + T_RTP_DEF);
                tp = imax(tp, m_wr[b] + T_CWD_DEF + T_BURST_DEF + T_WR_DEF);
                exp_q.push_back(pack_cmd(tp, 1, bg, bk, 0, 0, 0));
                m_pre[b]  = tp;
                m_open[b] = 1'b0;
                t = tp + 1;
            end
            ta = imax(t, m_pre[b] + T_RP_DEF);
            ta = imax(ta, g_act_t + ((bg == g_act_bg) ? T_RRD_L_DEF : T_RRD_S_DEF));
            exp_q.push_back(pack_cmd(ta, 2, bg, bk, row, 0, 0));
            m_open[b] = 1'b1;
            m_row[b]  = row;
            m_act[b]  = ta;
            g_act_t   = ta;
            g_act_bg  = bg;
            t = ta + 1;
        end
        tc = imax(t, m_act[b] + T_RCD_DEF);
        tc = imax(tc, g_col_t + ((bg == g_col_bg) ? T_CCD_L_DEF : T_CCD_S_DEF));
        if (!wr)
            tc = imax(tc, g_wr_t + T_CWD_DEF + T_BURST_DEF +
                          ((bg == g_wr_bg) ? T_WTR_L_DEF : T_WTR_S_DEF));
        exp_q.push_back(pack_cmd(tc, wr ? 4 : 3, bg, bk, 0, col, hit));
        if (wr) begin
            m_wr[b] = tc;
            g_wr_t  = tc;
            g_wr_bg = bg;
        end else begin
            m_rd[b] = tc;
        end
        g_col_t  = tc;
        g_col_bg = bg;
    endtask

    typedef struct {
        int op;
        int bg;
        int bank;
        int row;
        int col;
        int pre_dly;
        int act_dly;
        int col_dly;
        int hit;
    } vec_t;

    vec_t vt[8];

    initial begin
        int acc, n, op, bg, bk, row, col;

        // Directed sequence, issued back to back from reset; delays relative to accept.
        vt[0] = '{0, 0, 0, 'h10, 'h005, -1,  2, 26, 0};  // cold read
        vt[1] = '{0, 0, 0, 'h10, 'h011, -1, -1,  7, 1};  // same-row hit, tCCD_L
        vt[2] = '{2, 0, 0, 'h20, 'h7ff, 19, 43, 67, 0};  // conflict, PRE at ACT+tRAS
        vt[3] = '{1, 1, 2, 'h05, 'h100, -1,  2, 26, 0};  // cold write
        vt[4] = '{0, 1, 2, 'h05, 'h101, -1, -1, 35, 1};  // RD 36 after WR, same bg
        vt[5] = '{1, 1, 2, 'h05, 'h102, -1, -1,  7, 1};  // WR hit, tCCD_L
        vt[6] = '{0, 2, 0, 'h07, 'h003, -1,  2, 27, 0};  // RD 28 after WR, other bg
        vt[7] = '{0, 1, 2, 'h09, 'h040, 15, 39, 63, 0};  // conflict, PRE at write recovery

        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_addr  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_cmd_type",  32'(cmd_type),  32'd0);
        chk("rst_page_hit",  32'(page_hit),  32'd0);
        chk("rst_cmd_bg",    32'(cmd_bg),    32'd0);
        chk("rst_cmd_bank",  32'(cmd_bank),  32'd0);
        chk("rst_cmd_row",   32'(cmd_row),   32'd0);
        chk("rst_cmd_col",   32'(cmd_col),   32'd0);

        for (int i = 0; i < 8; i++) begin
            send_req(vt[i].op, mk_addr(vt[i].bg, vt[i].bank, vt[i].row, vt[i].col), acc);
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
            if (vt[i].pre_dly >= 0)
                exp_q.push_back(pack_cmd(acc + vt[i].pre_dly, 1, vt[i].bg, vt[i].bank, 0, 0, 0));
            if (vt[i].act_dly >= 0)
                exp_q.push_back(pack_cmd(acc + vt[i].act_dly, 2, vt[i].bg, vt[i].bank, vt[i].row, 0, 0));
            exp_q.push_back(pack_cmd(acc + vt[i].col_dly, (vt[i].op == 1) ? 4 : 3,
                                     vt[i].bg, vt[i].bank, 0, vt[i].col, vt[i].hit));
            wait_idle();
            check_cmds($sformatf("vec%0d", i));
        end

        // Reset between ACT and RD: outputs clear at once and the RD never appears.
        send_req(0, mk_addr(3, 1, 'h44, 'h012), acc);
        n = 0;
        while (act_q.size() == 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("midrst_act_seen", 32'(act_q.size()), 32'd1);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_busy",      32'(busy),      32'd0);
        chk("midrst_cmd_row",   32'(cmd_row),   32'd0);
        chk("midrst_cmd_bg",    32'(cmd_bg),    32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("midrst_no_partial", 32'(act_q.size()), 32'd1);
        act_q.delete();
        model_reset();

        // Same-row read again: bank was closed by reset, so a fresh ACT is due.
        send_req(0, mk_addr(3, 1, 'h44, 'h012), acc);
        model_req(acc, 0, 3, 1, 'h44, 'h012);
        wait_idle();
        check_cmds("midrst_reissue");

        // Random traffic over a few banks/rows to mix hits, misses and conflicts.
        for (int i = 0; i < 40; i++) begin
            op  = $urandom_range(0, 2);
            bg  = $urandom_range(0, 2);
            bk  = $urandom_range(0, 1);
            row = $urandom_range(0, 2);
            col = $urandom_range(0, 2047);
            n   = $urandom_range(0, 3);
            repeat (n) begin
                @(posedge clk); #1;
            end
            send_req(op, mk_addr(bg, bk, row, col), acc);
            model_req(acc, op, bg, bk, row, col);
            wait_idle();
            check_cmds($sformatf("rand%0d", i));
        end

        chk("nop_when_idle", 32'(proto_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr4_cmd_scheduler.md
Name: ddr4_cmd_scheduler

Overview:
- Single-request DDR4 command sequencer for the memory-controller simulator.
- Accepts one decoded CPU request at a time (read, write or instruction fetch, 33-bit address) and tracks the open row of all 16 banks (4 bank groups x 4 banks).
- Issues the legal PRE/ACT/RD/WR sequence under an open-page policy, enforcing bank timing in clk cycles.
- Sits between the request queue and the DRAM command/trace output.

Parameters:
- T_RP, 24, PRE to ACT, same bank
- T_RCD, 24, ACT to RD/WR, same bank
- T_RAS, 52, ACT to PRE, same bank
- T_RTP, 12, RD to PRE, same bank
- T_WR, 20, write recovery; WR to PRE = T_CWD+T_BURST+T_WR
- T_CWD, 20, write CAS latency
- T_BURST, 4, burst length in cycles
- T_RRD_L / T_RRD_S, 6 / 4, ACT to ACT, same / different bank group
- T_CCD_L / T_CCD_S, 8 / 4, column to column, same / different bank group
- T_WTR_L / T_WTR_S, 12 / 4, WR to RD = T_CWD+T_BURST+T_WTR_x

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  scheduler can accept a request
- req_op  in  2  0 data read, 1 write, 2 instruction fetch (treated as read)
- req_addr  in  33  row [32:18], col-hi [17:10], bank [9:8], bg [7:6], col-lo [5:3]; [2:0] ignored
- cmd_valid  out  1  one-cycle pulse per issued command
- cmd_type  out  3  0 NOP, 1 PRE, 2 ACT, 3 RD, 4 WR
- cmd_bg  out  2  bank group
- cmd_bank  out  2  bank
- cmd_row  out  15  row; valid with ACT
- cmd_col  out  11  {addr[17:10], addr[5:3]}; valid with RD/WR
- page_hit  out  1  pulses with a column command that needed no PRE/ACT
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (asynchronous, any cycle including mid-sequence):
  - all outputs 0 except req_ready=1
  - all 16 banks marked closed; every timing counter 0; FSM to IDLE
  - any in-flight request is dropped, with no partial command stream
- Handshake:
  - A request is accepted in the cycle where req_valid && req_ready; fields are latched.
  - req_ready=1 only in IDLE. Acceptance is registered, so the first command can issue no earlier than the next cycle.
- FSM:
  - IDLE -> CHECK on accept.
  - CHECK (1 cycle): bank open with same row -> COL (hit); bank closed -> ACT; open with different row -> PRE.
  - PRE: waits for bank pre_cnt==0, issues PRE, marks bank closed, loads act_cnt=T_RP -> ACT.
  - ACT: waits for bank act_cnt==0 and rrd_cnt==0. Issues ACT, records the open row, loads col_cnt=T_RCD and pre_cnt=T_RAS. rrd_cnt loads T_RRD_L for a following ACT to the same bg, otherwise T_RRD_S; store last_act_bg -> COL.
  - COL: waits for bank col_cnt==0, ccd gap (T_CCD_L if same bg as last column command, else T_CCD_S) and, for RD, the WTR gap since the last WR.
    - Issues RD or WR.
    - pre_cnt = max(pre_cnt, T_RTP) for RD; max(pre_cnt, T_CWD+T_BURST+T_WR) for WR.
    - Then -> IDLE.
- Timing rule: a counter loaded at issue cycle t permits the dependent command at cycle t+N exactly, never earlier. When stalled only on that constraint, it issues exactly at t+N.
- Counters decrement once per cycle and saturate at 0. Width is 8 bits, sufficient for all defaults; a parameter value above 255 is an elaboration error.
- At most one command per cycle. cmd_* fields hold their last value when cmd_valid=0; cmd_type=NOP then.
- page_hit asserts only on the COL command of a CHECK->COL path.

Optional Feature:
- MC_CLOSED_PAGE_EN defined: after every RD/WR the FSM enters an AUTO_PRE state. It waits for that bank's pre_cnt==0, issues PRE, marks the bank closed, loads act_cnt=T_RP, then returns to IDLE. page_hit never asserts.
- Undefined: pure open-page policy; rows stay open until a conflicting request arrives.

Decomposition:
- Package mc_defs holds:
  - timing defaults
  - cmd_type enum
  - req_op enum
  - address-field typedef and slice functions for row/col/bank/bg
- Sub-module ddr4_bank_timer: one instance per bank (16). It holds open flag, open row, act_cnt, col_cnt and pre_cnt, and exposes "can_act/can_col/can_pre".
- The parent owns the FSM plus the global rrd, ccd and wtr counters.

Test Plan:
- Cold read, bg0 b0 row 0x10, accept at cycle 0 -> ACT at 2, RD at 26, page_hit=0.
- Same-row read to bg0 b0 after the previous RD at 26 -> RD at 34 (T_CCD_L), page_hit=1, no PRE/ACT.
- Row conflict, bg0 b0 row 0x20 right after the cold read -> PRE at 54 (ACT+T_RAS), ACT at 78, RD at 102.
- WR to bg1 b2 then RD to bg1 b2 same row -> RD exactly 36 cycles after WR (T_CWD+T_BURST+T_WTR_L); changing the RD to bg2 -> 28.
- Back-to-back cold reads to bg0 b0 and bg0 b1 -> second ACT no earlier than first ACT+6. With bg1 b0 instead -> +4, limited only if FSM latency is larger.
- rst asserted between ACT and RD -> outputs 0 immediately, req_ready=1. A re-issued same-row read needs a fresh ACT (bank closed).
